// File: rtl/debounce_arbiter_pkg.sv
// Shared types and the round-robin search used by the debounce arbiter.
package debounce_arbiter_pkg;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned IDX_W  = 5;

  typedef enum logic [0:0] {ARB_IDLE, ARB_PRESENT} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_grant_t;

  // First set bit after last_grant, wrapping modulo n_ch.
  function automatic rr_grant_t next_rr(input logic [MAX_CH-1:0] pending,
                                        input int unsigned       n_ch,
                                        input int unsigned       last_grant);
    rr_grant_t   g;
    int unsigned c;
    g = '0;
    for (int unsigned k = 1; k <= MAX_CH; k++) begin
      c = (last_grant + k) % n_ch;
      if (k <= n_ch && !g.found && pending[c[IDX_W-1:0]]) begin
        g.found = 1'b1;
        g.idx   = c[IDX_W-1:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/debounce_arbiter_tick.sv
// Free-running prescaler: one-cycle tick every TICK_CYCLES clocks.
module tick_gen
  import debounce_arbiter_pkg::*;
#(
  parameter int TICK_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/debounce_arbiter.sv
// Multi-channel debouncer sharing one prescaler; debounced edges are queued
// as pending flags and delivered round-robin over a valid/ready port.
module debounce_arbiter
  import debounce_arbiter_pkg::*;
#(
  parameter  int N_CH         = 4,
  parameter  int TICK_CYCLES  = 100000,
  parameter  int STABLE_TICKS = 5,
  localparam int CH_W         = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] debounced,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CH_W-1:0] evt_ch,
  output logic            evt_level,
  output logic            overrun
);

  localparam int               CNT_W    = $clog2(STABLE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic tick;

  tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  logic [N_CH-1:0]            sync1_q, sync2_q;
  logic [N_CH-1:0]            deb_q, deb_d, pend_q, pend_d, flip, clr;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                       ovr_q, ovr_d;
  arb_state_t                 state_q, state_d;
  logic [CH_W-1:0]            last_q, last_d, ch_q, ch_d;
  logic                       lvl_q, lvl_d;
  logic [MAX_CH-1:0]          pend_ext;
  rr_grant_t                  grant;

  // A matching input clears the count before a tick can advance it.
  always_comb begin
    flip  = '0;
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip[i]  = 1'b1;
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Set beats clear, so a flip on the channel being granted is re-queued.
  assign deb_d  = deb_q ^ flip;
  assign pend_d = (pend_q & ~clr) | flip;
  assign ovr_d  = |(flip & pend_q & ~clr);

  always_comb begin
    pend_ext               = '0;
    pend_ext[N_CH-1:0]     = pend_q;
    grant                  = next_rr(pend_ext, N_CH, 32'(last_q));
    state_d                = state_q;
    last_d                 = last_q;
    ch_d                   = ch_q;
    lvl_d                  = lvl_q;
    clr                    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (grant.found) begin
          ch_d      = grant.idx[CH_W-1:0];
          lvl_d     = deb_q[ch_d];
          clr[ch_d] = 1'b1;
          last_d    = ch_d;
          state_d   = ARB_PRESENT;
        end
      end
      ARB_PRESENT: if (evt_ready) state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      state_q <= ARB_IDLE;
      last_q  <= CH_W'(N_CH - 1);
      ch_q    <= '0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= noisy;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      lvl_q   <= lvl_d;
    end
  end

  assign debounced = deb_q;
  assign evt_valid = (state_q == ARB_PRESENT);
  assign evt_ch    = ch_q;
  assign evt_level = lvl_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_debounce_arbiter.sv
// Scoreboard bench for debounce_arbiter (N_CH=4, TICK_CYCLES=4, STABLE_TICKS=3).
module tb_debounce_arbiter;

  localparam int N_CH = 4;

  typedef struct {
    int ch;
    int lvl;
  } ev_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N_CH-1:0] noisy;
  logic [N_CH-1:0] debounced;
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_ch;
  logic            evt_level;
  logic            overrun;

  debounce_arbiter #(.N_CH(N_CH), .TICK_CYCLES(4), .STABLE_TICKS(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .noisy     (noisy),
    .debounced (debounced),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_err = 0;
  ev_t exp_q[$];
  int  rd = 0;

  // monitor-owned observation state
  int  hs_cnt    = 0;
  int  valid_cyc = 0;
  int  ovr_cnt   = 0;
  int  obs_ch[64];
  int  obs_lvl[64];

  always @(negedge clk) begin
    if (reset_n) begin
      if (evt_valid) valid_cyc++;
      if (overrun)   ovr_cnt++;
      if (evt_valid && evt_ready) begin
        obs_ch[hs_cnt % 64]  = int'(evt_ch);
        obs_lvl[hs_cnt % 64] = int'(evt_level);
        hs_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int ch, input int lvl);
    ev_t e;
    e.ch  = ch;
    e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic wait_deb(input logic [N_CH-1:0] mask, input logic [N_CH-1:0] val,
                          input int budget, output int n);
    n = 0;
    while (((debounced & mask) !== (val & mask)) && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int t = 0;
    while (!evt_valid && t < budget) begin
      step();
      t++;
    end
    check({tag, "_valid"}, evt_valid, 1'b1);
  endtask

  // Compare every expected event against what the monitor saw, in order.
  task automatic drain(input string tag, input int budget);
    int  t = 0;
    int  n;
    ev_t e;
    while ((hs_cnt - rd) < exp_q.size() && t < budget) begin
      step();
      t++;
    end
    repeat (4) step();
    check({tag, "_count"}, hs_cnt - rd, exp_q.size());
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      if (rd < hs_cnt) begin
        check({tag, "_ch"},  obs_ch[rd % 64],  e.ch);
        check({tag, "_lvl"}, obs_lvl[rd % 64], e.lvl);
        rd++;
      end
    end
    rd = hs_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, v0, o0;

    // reset with all inputs high
    reset_n   = 1'b0;
    noisy     = 4'hF;
    evt_ready = 1'b1;
    repeat (3) step();
    check("rst_deb", debounced, 4'h0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    reset_n = 1'b1;
    wait_deb(4'hF, 4'hF, 20, n);
    check("rst_rel_lat_ok", (n <= 14), 1'b1);
    for (int c = 0; c < N_CH; c++) push(c, 1);
    drain("rst_rel", 40);
    noisy = 4'h0;
    wait_deb(4'hF, 4'h0, 20, n);
    check("fall_all_deb", debounced, 4'h0);
    for (int c = 0; c < N_CH; c++) push(c, 0);
    drain("fall_all", 40);

    // clean edge on ch0
    noisy[0] = 1'b1;
    wait_deb(4'h1, 4'h1, 20, n);
    check("edge_lat_ok", (n >= 11 && n <= 14), 1'b1);
    push(0, 1);
    drain("edge", 20);

    // glitch on ch1
    v0 = valid_cyc;
    noisy[1] = 1'b1;
    repeat (6) step();
    noisy[1] = 1'b0;
    repeat (20) step();
    check("glitch_deb", debounced[1], 1'b0);
    check("glitch_valid", valid_cyc - v0, 0);
    check("glitch_cnt", dut.cnt_q[1], 0);

    // arbitration between ch1 and ch3
    evt_ready = 1'b0;
    noisy[1]  = 1'b1;
    noisy[3]  = 1'b1;
    wait_valid("arb", 30);
    check("arb_first_ch", evt_ch, 1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!evt_valid || evt_ch !== 2'd1 || evt_level !== 1'b1) bad++;
    end
    check("arb_hold", bad, 0);
    evt_ready = 1'b1;
    step();
    check("arb_bubble", evt_valid, 1'b0);
    step();
    check("arb_second_valid", evt_valid, 1'b1);
    check("arb_second_ch", evt_ch, 3);
    push(1, 1);
    push(3, 1);
    drain("arb", 20);

    // ch0 and ch2 flip together: search restarts at ch0; ch2 then overruns
    evt_ready = 1'b0;
    o0        = ovr_cnt;
    noisy[0]  = 1'b0;
    noisy[2]  = 1'b1;
    wait_valid("ovr", 30);
    check("ovr_first_ch", evt_ch, 0);
    check("ovr_first_lvl", evt_level, 1'b0);
    wait_deb(4'h4, 4'h4, 20, n);
    repeat (2) step();
    noisy[2] = 1'b0;
    wait_deb(4'h4, 4'h0, 20, n);
    check("ovr_deb2", debounced[2], 1'b0);
    repeat (2) step();
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_held_ch", evt_ch, 0);
    push(0, 0);
    push(2, 0);
    evt_ready = 1'b1;
    drain("ovr", 20);

    // reset while an event is presented
    evt_ready = 1'b0;
    noisy[1]  = 1'b0;
    wait_valid("mid", 30);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_async_drop", evt_valid, 1'b0);
    noisy = 4'h0;
    repeat (3) step();
    reset_n   = 1'b1;
    v0        = valid_cyc;
    evt_ready = 1'b1;
    repeat (30) step();
    check("mid_no_stale", valid_cyc - v0, 0);
    check("mid_deb", debounced, 4'h0);
    drain("mid", 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
